mem_requester: RTL

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_req_pkg.sv | 34 +++
 rtl/byte_lane_merge.sv | 53 +++++
 rtl/mem_requester.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_req_pkg.sv
// Shared encodings for the CPU-side memory requester: access sizes, FSM states
// and the alignment rule used to reject a request before it touches memory.
package mem_req_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Size 11 has no meaning, so it is reported like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Big-endian lane handling: extracts and extends sub-word load data and merges
// sub-word store data into a previously read word.
module byte_lane_merge
    import mem_req_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] rword,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic [4:0]        shamt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        // Lane 00 is the most significant byte, so the shift is (3 - lane) bytes.
        case (size)
            SIZE_BYTE: shamt = {~lane, 3'b000};
            SIZE_HALF: shamt = lane[1] ? 5'd0 : 5'd16;
            default:   shamt = 5'd0;
        endcase

        shifted = rword >> shamt;
        byte_s  = signed'(shifted[7:0]);
        half_s  = signed'(shifted[15:0]);

        load_data = rword;
        mask      = '1;
        case (size)
            SIZE_BYTE: begin
                load_data = sign ? 32'(byte_s) : {24'd0, shifted[7:0]};
                mask      = 32'h0000_00FF << shamt;
            end
            SIZE_HALF: begin
                load_data = sign ? 32'(half_s) : {16'd0, shifted[15:0]};
                mask      = 32'h0000_FFFF << shamt;
            end
            default: begin
                load_data = rword;
                mask      = '1;
            end
        endcase

        merge_data = (rword & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_requester.sv
// CPU load/store requester: accepts one access at a time, performs word or
// read-modify-write sub-word traffic to a word-addressed memory, and returns a response.
module mem_requester
    import mem_req_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_adress,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_adress,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state;
    logic              ready_q;
    logic              mem_write_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              write_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    byte_lane_merge u_lane (
        .size       (size_q),
        .sign       (sign_q),
        .lane       (lane_q),
        .rword      (mem_read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // A reset edge taken mid-operation must never commit a store or look like a handshake.
    assign mem_write = mem_write_q & ~reset;
    assign req_ready = ready_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ready_q        <= 1'b1;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= '0;
            mem_read       <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_adress     <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        size_q     <= req_size;
                        sign_q     <= req_sign;
                        write_q    <= req_write;
                        lane_q     <= req_adress[1:0];
                        wdata_q    <= req_wdata;
                        mem_adress <= {2'b00, req_adress[ADDR_W-1:2]};
                        ready_q    <= 1'b0;
                        if (is_misaligned(req_size, req_adress[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && req_size == SIZE_WORD) begin
                            state          <= WRITE;
                            mem_write_q    <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state    <= READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    mem_read <= 1'b0;
                    if (write_q) begin
                        state          <= WRITE;
                        mem_write_q    <= 1'b1;
                        mem_write_data <= merge_data;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    mem_write_q <= 1'b0;
                    state       <= RESP;
                    resp_valid  <= 1'b1;
                    resp_error  <= 1'b0;
                    resp_rdata  <= '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        ready_q    <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    ready_q     <= 1'b1;
                    mem_read    <= 1'b0;
                    mem_write_q <= 1'b0;
                    resp_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
